// File: rtl/ysyx_22050019_regfile_sb_if.sv
// rtl/ysyx_22050019_regfile_sb_if.sv - ID/WB bundle for the scoreboarded register file
interface ysyx_22050019_regfile_sb_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2
);
    logic [NUM_WR-1:0]            wen;
    logic [NUM_WR*ADDR_WIDTH-1:0] waddr;
    logic [NUM_WR*DATA_WIDTH-1:0] wdata;
    logic [NUM_RD*ADDR_WIDTH-1:0] raddr;
    logic [NUM_RD*DATA_WIDTH-1:0] rdata;
    logic [NUM_RD-1:0]            rvalid;
    logic                         issue_en;
    logic [ADDR_WIDTH-1:0]        issue_rd;
    logic                         flush;
    logic [ADDR_WIDTH:0]          pend_cnt;

    modport master (
        output wen, waddr, wdata, raddr, issue_en, issue_rd, flush,
        input  rdata, rvalid, pend_cnt
    );

    modport slave (
        input  wen, waddr, wdata, raddr, issue_en, issue_rd, flush,
        output rdata, rvalid, pend_cnt
    );
endinterface

// File: rtl/ysyx_22050019_regfile_sb.sv
// rtl/ysyx_22050019_regfile_sb.sv - multi-port register file with scoreboard; BYPASS_EN enables WB->ID forwarding
module ysyx_22050019_regfile_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    ysyx_22050019_regfile_sb_if.slave    bus
);
    localparam int NREG = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]        regs [NREG];
    logic [NREG-1:0]              pending;
    logic [NREG-1:0]              pending_nxt;
    logic [ADDR_WIDTH:0]          pend_cnt_q;
    logic [ADDR_WIDTH:0]          cnt_nxt;
    logic [NUM_RD*DATA_WIDTH-1:0] rdata_c;
    logic [NUM_RD-1:0]            rvalid_c;
    logic [ADDR_WIDTH-1:0]        ra;

    // Ascending port order: the last non-blocking write wins, so higher ports take priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (bus.wen[k] && (bus.waddr[k*ADDR_WIDTH +: ADDR_WIDTH] != '0))
                    regs[bus.waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.wdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Clear on write, then set on issue (set wins), then flush overrides everything.
    always_comb begin
        pending_nxt = pending;
        for (int k = 0; k < NUM_WR; k++) begin
            if (bus.wen[k])
                pending_nxt[bus.waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
        end
        if (bus.issue_en)
            pending_nxt[bus.issue_rd] = 1'b1;
        if (bus.flush)
            pending_nxt = '0;
        pending_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int r = 0; r < NREG; r++)
            cnt_nxt = cnt_nxt + {{ADDR_WIDTH{1'b0}}, pending_nxt[r]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            pend_cnt_q <= '0;
        end else begin
            pending    <= pending_nxt;
            pend_cnt_q <= cnt_nxt;
        end
    end

    always_comb begin
        rdata_c  = '0;
        rvalid_c = '0;
        ra       = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            rdata_c[i*DATA_WIDTH +: DATA_WIDTH] = regs[ra];
            rvalid_c[i] = ~pending[ra];
`ifdef BYPASS_EN
            for (int k = 0; k < NUM_WR; k++) begin
                if (bus.wen[k] && (bus.waddr[k*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
                    rdata_c[i*DATA_WIDTH +: DATA_WIDTH] = bus.wdata[k*DATA_WIDTH +: DATA_WIDTH];
                    rvalid_c[i] = 1'b1;
                end
            end
`endif
            if (ra == '0) begin
                rdata_c[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                rvalid_c[i] = 1'b1;
            end
        end
    end

    assign bus.rdata    = rdata_c;
    assign bus.rvalid   = rvalid_c;
    assign bus.pend_cnt = pend_cnt_q;
endmodule

// File: tb/tb_ysyx_22050019_regfile_sb.sv
// tb/tb_ysyx_22050019_regfile_sb.sv - randomized bench with reference model for ysyx_22050019_regfile_sb
module tb_ysyx_22050019_regfile_sb;
    localparam int AW   = 5;
    localparam int DW   = 64;
    localparam int NR   = 2;
    localparam int NW   = 2;
    localparam int NREG = 2 ** AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_22050019_regfile_sb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

    ysyx_22050019_regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [DW-1:0] m_regs [NREG];
    bit            m_pend [NREG];
    int            m_cnt;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Highest-numbered write port targeting register a this cycle, if any.
    function automatic bit wr_hit(input int a, output logic [DW-1:0] d);
        d = '0;
        if (a == 0) return 1'b0;
        for (int k = NW - 1; k >= 0; k--) begin
            if (bus.wen[k] && int'(bus.waddr[k*AW +: AW]) == a) begin
                d = bus.wdata[k*DW +: DW];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit any_wr(input int a);
        for (int k = 0; k < NW; k++)
            if (bus.wen[k] && int'(bus.waddr[k*AW +: AW]) == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit will_pend(input int a);
        if (a == 0 || bus.flush) return 1'b0;
        if (bus.issue_en && int'(bus.issue_rd) == a) return 1'b1;
        if (any_wr(a)) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic int next_cnt();
        int n = 0;
        for (int r = 0; r < NREG; r++) n += int'(will_pend(r));
        return n;
    endfunction

    function automatic logic [DW-1:0] exp_rdata(input int i);
        int a = int'(bus.raddr[i*AW +: AW]);
        logic [DW-1:0] d;
        if (a == 0) return '0;
`ifdef BYPASS_EN
        if (wr_hit(a, d)) return d;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_rvalid(input int i);
        int a = int'(bus.raddr[i*AW +: AW]);
        logic [DW-1:0] d;
        if (a == 0) return 1'b1;
`ifdef BYPASS_EN
        if (wr_hit(a, d)) return 1'b1;
`endif
        return !m_pend[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                m_regs[r] <= '0;
                m_pend[r] <= 1'b0;
            end
            m_cnt <= 0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                logic [DW-1:0] d;
                if (wr_hit(r, d)) m_regs[r] <= d;
                m_pend[r] <= will_pend(r);
            end
            m_cnt <= next_cnt();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NR; i++) begin
                chk($sformatf("model rdata%0d", i), bus.rdata[i*DW +: DW], exp_rdata(i));
                chk($sformatf("model rvalid%0d", i), {63'd0, bus.rvalid[i]}, {63'd0, exp_rvalid(i)});
            end
            chk("model pend_cnt", {58'd0, bus.pend_cnt}, 64'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wen      = '0;
        bus.issue_en = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic wr(input int p, input int a, input logic [DW-1:0] d);
        bus.wen[p]             = 1'b1;
        bus.waddr[p*AW +: AW]  = a[AW-1:0];
        bus.wdata[p*DW +: DW]  = d;
    endtask

    task automatic issue(input int a);
        bus.issue_en = 1'b1;
        bus.issue_rd = a[AW-1:0];
    endtask

    task automatic rd(input int p, input int a);
        bus.raddr[p*AW +: AW] = a[AW-1:0];
    endtask

    task automatic randomize_inputs(input bit full_range);
        for (int k = 0; k < NW; k++) begin
            bus.wen[k] = ($urandom_range(0, 2) == 0);
            bus.waddr[k*AW +: AW] = full_range ? AW'($urandom) : AW'($urandom_range(0, 7));
            bus.wdata[k*DW +: DW] = {$urandom, $urandom};
        end
        for (int i = 0; i < NR; i++)
            bus.raddr[i*AW +: AW] = full_range ? AW'($urandom) : AW'($urandom_range(0, 7));
        bus.issue_en = ($urandom_range(0, 4) < 2);
        bus.issue_rd = full_range ? AW'($urandom) : AW'($urandom_range(0, 7));
        bus.flush    = ($urandom_range(0, 19) == 0);
    endtask

    initial begin
        idle();
        bus.waddr = '0;
        bus.wdata = '0;
        bus.raddr = '0;
        bus.issue_rd = '0;
        rst_n = 1'b0;
        chk_en = 1'b1;

        // Reset held with random activity
        repeat (4) begin
            step();
            randomize_inputs(1'b1);
        end
        step();
        idle();
        rd(0, 3); rd(1, 0);
        @(negedge clk);
        chk("reset pend_cnt", {58'd0, bus.pend_cnt}, 64'd0);
        chk("reset rvalid", {62'd0, bus.rvalid}, 64'd3);
        chk("reset rdata0", bus.rdata[0 +: DW], 64'd0);

        // Release: first write lands on the next posedge
        step();
        rst_n = 1'b1;
        wr(0, 10, 64'h77);
        rd(0, 10);
        step();
        idle();
        @(negedge clk);
        chk("first write after reset", bus.rdata[0 +: DW], 64'h77);

        // Basic write and x0
        step();
        wr(0, 5, 64'h1234);
        step();
        idle();
        rd(0, 5);
        @(negedge clk);
        chk("write x5", bus.rdata[0 +: DW], 64'h1234);
        step();
        wr(1, 0, 64'hFFFF);
        rd(1, 0);
        step();
        idle();
        @(negedge clk);
        chk("x0 rdata", bus.rdata[DW +: DW], 64'd0);
        chk("x0 rvalid", {63'd0, bus.rvalid[1]}, 64'd1);

        // Write conflict
        step();
        wr(0, 7, 64'hAA);
        wr(1, 7, 64'hBB);
        step();
        idle();
        rd(0, 7);
        @(negedge clk);
        chk("conflict x7", bus.rdata[0 +: DW], 64'hBB);

        // Scoreboard
        step();
        issue(3);
        step();
        idle();
        rd(0, 3);
        @(negedge clk);
        chk("issue x3 rvalid", {63'd0, bus.rvalid[0]}, 64'd0);
        chk("issue x3 pend_cnt", {58'd0, bus.pend_cnt}, 64'd1);
        step();
        wr(0, 3, 64'h55);
        step();
        idle();
        @(negedge clk);
        chk("wb x3 rvalid", {63'd0, bus.rvalid[0]}, 64'd1);
        chk("wb x3 pend_cnt", {58'd0, bus.pend_cnt}, 64'd0);
        chk("wb x3 rdata", bus.rdata[0 +: DW], 64'h55);
        step();
        issue(3);
        wr(1, 3, 64'h66);
        step();
        idle();
        @(negedge clk);
        chk("issue+wb x3 rvalid", {63'd0, bus.rvalid[0]}, 64'd0);
        chk("issue+wb x3 pend_cnt", {58'd0, bus.pend_cnt}, 64'd1);
        step();
        wr(0, 3, 64'h66);
        step();
        idle();

        // Flush
        issue(1);
        step();
        issue(2);
        step();
        issue(4);
        step();
        idle();
        @(negedge clk);
        chk("three pending", {58'd0, bus.pend_cnt}, 64'd3);
        step();
        bus.flush = 1'b1;
        issue(6);
        step();
        idle();
        rd(0, 6); rd(1, 4);
        @(negedge clk);
        chk("flush pend_cnt", {58'd0, bus.pend_cnt}, 64'd0);
        chk("flush rvalid", {62'd0, bus.rvalid}, 64'd3);

        // Same-cycle write versus read of a pending register
        step();
        issue(9);
        step();
        idle();
        wr(1, 9, 64'hDEAD);
        rd(1, 9);
        @(negedge clk);
`ifdef BYPASS_EN
        chk("bypass rdata1", bus.rdata[DW +: DW], 64'hDEAD);
        chk("bypass rvalid1", {63'd0, bus.rvalid[1]}, 64'd1);
`else
        chk("no-bypass rdata1", bus.rdata[DW +: DW], 64'd0);
        chk("no-bypass rvalid1", {63'd0, bus.rvalid[1]}, 64'd0);
`endif
        step();
        idle();
        @(negedge clk);
        chk("after wb rdata1", bus.rdata[DW +: DW], 64'hDEAD);
        chk("after wb rvalid1", {63'd0, bus.rvalid[1]}, 64'd1);

        // Random traffic with occasional asynchronous reset pulses
        for (int c = 0; c < 3000; c++) begin
            step();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            randomize_inputs(c[0]);
        end
        step();
        idle();
        @(negedge clk);
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
